deadtime_gen: RTL and testbench

DEADTIME_GEN -- requirements
Module: deadtime_gen

---
 rtl/deadtime_pkg.sv | 21 ++
 rtl/deadtime_phase.sv | 111 +++++++++++
 rtl/deadtime_gen.sv | 104 ++++++++++
 tb/tb_deadtime_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/deadtime_pkg.sv
// -----------------------------------------------------------------------------
// deadtime_pkg
// Shared definitions for the three-phase dead-time generator.
//   phase_state_t   : per-phase FSM state encoding
//   DT_WIDTH_DEF    : default width of the dead-time count
//   DT_DEFAULT_DEF  : default dead-time (clk cycles) after reset
// -----------------------------------------------------------------------------
package deadtime_pkg;

    localparam int DT_WIDTH_DEF   = 8;
    localparam int DT_DEFAULT_DEF = 8;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,   // both gates off, bridge not running
        ST_DT_H = 3'd1,   // both gates off, heading to high-side on
        ST_HIGH = 3'd2,   // high-side on
        ST_DT_L = 3'd3,   // both gates off, heading to low-side on
        ST_LOW  = 3'd4    // low-side on
    } phase_state_t;

endpackage

// File: rtl/deadtime_phase.sv
// -----------------------------------------------------------------------------
// deadtime_phase
// One half-bridge leg: FSM plus dead-time counter. Gate outputs are registered
// and decoded from the next state so they change on the same edge as the FSM.
//
// Ports
//   clk      in   clock, rising edge
//   rstb     in   asynchronous active-low reset
//   pwm      in   raw phase command, 1 = high-side on
//   halt     in   1 forces the leg to OFF on the next edge (enable low / fault)
//   dt_load  in   counter load value, already dt_eff-1
//   gate_h   out  registered high-side gate drive
//   gate_l   out  registered low-side gate drive
//
// The FSM state lives in the register 'state' (type phase_state_t) so it can
// be probed hierarchically.
// -----------------------------------------------------------------------------
module deadtime_phase
    import deadtime_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                pwm,
    input  logic                halt,
    input  logic [DT_WIDTH-1:0] dt_load,
    output logic                gate_h,
    output logic                gate_l
);

    phase_state_t        state, state_n;
    logic [DT_WIDTH-1:0] cnt, cnt_n;
    // Remembers whether the current DT_x was entered from OFF, so an aborted
    // short pulse returns to the state it actually came from.
    logic                from_off, from_off_n;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= ST_OFF;
            cnt      <= '0;
            from_off <= 1'b0;
            gate_h   <= 1'b0;
            gate_l   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            from_off <= from_off_n;
            gate_h   <= (state_n == ST_HIGH);
            gate_l   <= (state_n == ST_LOW);
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        from_off_n = from_off;
        if (halt) begin
            state_n = ST_OFF;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_n    = pwm ? ST_DT_H : ST_DT_L;
                    cnt_n      = dt_load;
                    from_off_n = 1'b1;
                end
                ST_LOW: begin
                    if (pwm) begin
                        state_n    = ST_DT_H;
                        cnt_n      = dt_load;
                        from_off_n = 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (!pwm) begin
                        state_n    = ST_DT_L;
                        cnt_n      = dt_load;
                        from_off_n = 1'b0;
                    end
                end
                ST_DT_H: begin
                    if (!pwm) begin
                        // Pulse shorter than dead-time: back out, no extra wait.
                        state_n = from_off ? ST_OFF : ST_LOW;
                        cnt_n   = '0;
                    end else if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        state_n = ST_HIGH;
                    end
                end
                ST_DT_L: begin
                    if (pwm) begin
                        state_n = from_off ? ST_OFF : ST_HIGH;
                        cnt_n   = '0;
                    end else if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        state_n = ST_LOW;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/deadtime_gen.sv
// -----------------------------------------------------------------------------
// deadtime_gen
// Three-phase dead-time generator: turns raw SVM phase commands into
// complementary high/low gate drives with a programmable both-off interval.
//
// Ports
//   clk         in   clock, rising edge
//   rstb        in   asynchronous active-low reset
//   pwm_in[2:0] in   raw phase commands (bit0=A, bit1=B, bit2=C), 1 = high on
//   dt_in       in   new dead-time in clk cycles (0 behaves as 1)
//   dt_wen      in   loads dt_in into the dead-time register
//   enable      in   bridge enable; 0 forces all gates off
//   fault       in   external fault, 1 = fault
//   fault_clr   in   clears the latched fault (latching build only)
//   gate_h_out  out  high-side gate drives
//   gate_l_out  out  low-side gate drives
//   faulted     out  fault state active, all gates held off
//
// Build option: DEADTIME_FAULT_LATCH_EN
//   defined   : faulted latches on fault and clears on fault_clr with fault=0
//               (fault wins when both are high)
//   undefined : faulted is fault registered once; fault_clr is unused
// -----------------------------------------------------------------------------
module deadtime_gen
    import deadtime_pkg::*;
#(
    parameter int DT_WIDTH   = DT_WIDTH_DEF,
    parameter int DT_DEFAULT = DT_DEFAULT_DEF
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [2:0]          pwm_in,
    input  logic [DT_WIDTH-1:0] dt_in,
    input  logic                dt_wen,
    input  logic                enable,
    input  logic                fault,
    input  logic                fault_clr,
    output logic [2:0]          gate_h_out,
    output logic [2:0]          gate_l_out,
    output logic                faulted
);

    localparam logic [DT_WIDTH-1:0] DT_RST = DT_WIDTH'(DT_DEFAULT);

    logic [DT_WIDTH-1:0] dt_r;
    logic [DT_WIDTH-1:0] dt_load;
    logic                faulted_r;
    logic                halt;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dt_r <= DT_RST;
        end else if (dt_wen) begin
            dt_r <= dt_in;
        end
    end

    // dt_eff = max(dt_r,1); the counter is loaded with dt_eff-1.
    assign dt_load = (dt_r == '0) ? '0 : (dt_r - 1'b1);

`ifdef DEADTIME_FAULT_LATCH_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            faulted_r <= 1'b0;
        end else if (fault) begin
            faulted_r <= 1'b1;
        end else if (fault_clr) begin
            faulted_r <= 1'b0;
        end
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            faulted_r <= 1'b0;
        end else begin
            faulted_r <= fault;
        end
    end
`endif

    assign faulted = faulted_r;

    // The raw fault input also halts the legs so gates drop on the very edge
    // the fault is sampled, not one edge later via faulted_r.
    assign halt = ~enable | fault | faulted_r;

    for (genvar i = 0; i < 3; i++) begin : g_phase
        deadtime_phase #(
            .DT_WIDTH (DT_WIDTH)
        ) u_phase (
            .clk     (clk),
            .rstb    (rstb),
            .pwm     (pwm_in[i]),
            .halt    (halt),
            .dt_load (dt_load),
            .gate_h  (gate_h_out[i]),
            .gate_l  (gate_l_out[i])
        );
    end

endmodule

// File: tb/tb_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_deadtime_gen
// Directed vectors push the expected {faulted, gate_h_out, gate_l_out} for the
// next clock edge into exp_q; a monitor pops and compares one entry per edge.
// The monitor also checks h/l overlap every cycle and, during the random
// section, that an opposite gate never turns on before dt_eff off cycles.
// -----------------------------------------------------------------------------
module tb_deadtime_gen;

    logic       clk = 1'b0;
    logic       rstb;
    logic [2:0] pwm_in;
    logic [7:0] dt_in;
    logic       dt_wen;
    logic       enable;
    logic       fault;
    logic       fault_clr;
    logic [2:0] gate_h_out;
    logic [2:0] gate_l_out;
    logic       faulted;

    logic [6:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    logic       wen_next = 1'b0;
    logic [7:0] din_next = 8'd0;

    int         off_run[3];
    int         last_side[3];
    int         gap_dt = 1;
    bit         chk_gap = 1'b0;

    deadtime_gen dut (
        .clk        (clk),
        .rstb       (rstb),
        .pwm_in     (pwm_in),
        .dt_in      (dt_in),
        .dt_wen     (dt_wen),
        .enable     (enable),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .gate_h_out (gate_h_out),
        .gate_l_out (gate_l_out),
        .faulted    (faulted)
    );

    // clock
    always #5 clk = ~clk;

    // driver tasks: inputs change on the falling edge
    task automatic drive(input logic [2:0] p, input logic e, input logic f, input logic c);
        @(negedge clk);
        pwm_in    = p;
        enable    = e;
        fault     = f;
        fault_clr = c;
        dt_wen    = wen_next;
        dt_in     = din_next;
        wen_next  = 1'b0;
    endtask

    task automatic cyc(input logic [2:0] p, input logic e, input logic f, input logic c,
                       input logic [2:0] eh, input logic [2:0] el, input logic ef);
        drive(p, e, f, c);
        exp_q.push_back({ef, eh, el});
    endtask

    task automatic rep(input int n, input logic [2:0] p, input logic [2:0] eh, input logic [2:0] el);
        for (int k = 0; k < n; k++) cyc(p, 1'b1, 1'b0, 1'b0, eh, el, 1'b0);
    endtask

    // monitor / scoreboard, samples 1 time unit after the active edge
    always @(posedge clk) begin
        logic [6:0] exp_v;
        int         side;
        #1;
        if (rstb === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (gate_h_out[i] & gate_l_out[i]) begin
                    n_fail++;
                    $display("FAIL overlap phase %0d: h=%b l=%b, required not both 1", i,
                             gate_h_out[i], gate_l_out[i]);
                end
                if (gate_h_out[i] | gate_l_out[i]) begin
                    side = gate_h_out[i] ? 1 : 2;
                    if (off_run[i] != 0 && chk_gap && side != last_side[i]) begin
                        n_checks++;
                        if (off_run[i] < gap_dt) begin
                            n_fail++;
                            $display("FAIL deadgap phase %0d: off for %0d cycles, required >= %0d",
                                     i, off_run[i], gap_dt);
                        end
                    end
                    last_side[i] = side;
                    off_run[i]   = 0;
                end else begin
                    off_run[i]++;
                end
            end
        end
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({faulted, gate_h_out, gate_l_out} !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got f=%b h=%b l=%b, required f=%b h=%b l=%b",
                         $time, faulted, gate_h_out, gate_l_out, exp_v[6], exp_v[5:3], exp_v[2:0]);
            end
        end
    end

    initial begin
        int d;
        int n;
        for (int i = 0; i < 3; i++) begin
            off_run[i]   = 0;
            last_side[i] = 0;
        end
        rstb = 1'b0; pwm_in = 3'b000; dt_in = 8'd0; dt_wen = 1'b0;
        enable = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({faulted, gate_h_out, gate_l_out} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got f=%b h=%b l=%b, required all 0", faulted, gate_h_out, gate_l_out);
        end
        rstb = 1'b1;

        // dead-time 4, then enable with all phases low
        wen_next = 1'b1; din_next = 8'd4;
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        rep(4, 3'b000, 3'b000, 3'b000);
        rep(2, 3'b000, 3'b000, 3'b111);

        // phase A rises: l falls at k, h rises at k+4
        rep(4, 3'b001, 3'b000, 3'b110);
        rep(3, 3'b001, 3'b001, 3'b110);

        // phase B 2-cycle pulse shorter than the dead-time
        rep(2, 3'b011, 3'b001, 3'b100);
        rep(3, 3'b001, 3'b001, 3'b110);

        // phase A falls
        rep(4, 3'b000, 3'b000, 3'b110);
        rep(2, 3'b000, 3'b000, 3'b111);

        // dt_in = 0 behaves as a single off cycle, both directions
        wen_next = 1'b1; din_next = 8'd0;
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0);
        rep(1, 3'b100, 3'b000, 3'b011);
        rep(2, 3'b100, 3'b100, 3'b011);
        rep(1, 3'b000, 3'b000, 3'b011);
        rep(2, 3'b000, 3'b000, 3'b111);

        // dt 4 count in progress keeps 4 while dt 10 is written; next uses 10
        wen_next = 1'b1; din_next = 8'd4;
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0);
        rep(1, 3'b100, 3'b000, 3'b011);
        wen_next = 1'b1; din_next = 8'd10;
        rep(3, 3'b100, 3'b000, 3'b011);
        rep(2, 3'b100, 3'b100, 3'b011);
        rep(10, 3'b000, 3'b000, 3'b011);
        rep(2, 3'b000, 3'b000, 3'b111);

        // fault while phase A is high
        wen_next = 1'b1; din_next = 8'd4;
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0);
        rep(4, 3'b001, 3'b000, 3'b110);
        rep(2, 3'b001, 3'b001, 3'b110);
`ifdef DEADTIME_FAULT_LATCH_EN
        cyc(3'b001, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1);
        for (int k = 0; k < 3; k++) cyc(3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
        cyc(3'b001, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
`else
        cyc(3'b001, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1);
        cyc(3'b001, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
`endif
        rep(4, 3'b001, 3'b000, 3'b000);
        rep(2, 3'b001, 3'b001, 3'b110);

        // asynchronous reset in the middle of a DT_L count on phase A
        rep(2, 3'b000, 3'b000, 3'b110);
        @(posedge clk);
        #3;
        rstb = 1'b0;
        #1;
        n_checks++;
        if ({faulted, gate_h_out, gate_l_out} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got f=%b h=%b l=%b, required all 0", faulted, gate_h_out, gate_l_out);
        end
        enable = 1'b0;
        pwm_in = 3'b000;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        // dt_r back to 8: first gate-on 8 cycles after enable
        rep(8, 3'b000, 3'b000, 3'b000);
        rep(2, 3'b000, 3'b000, 3'b111);

        // random segments: dead-time changed only while disabled
        for (int s = 0; s < 40; s++) begin
            d = $urandom_range(0, 15);
            wen_next = 1'b1; din_next = 8'(d);
            drive(pwm_in, 1'b0, 1'b0, 1'b0);
            drive(pwm_in, 1'b0, 1'b0, 1'b0);
            gap_dt  = (d == 0) ? 1 : d;
            chk_gap = 1'b1;
            n = $urandom_range(20, 60);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) drive(3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);
                else                           drive(pwm_in, 1'b1, 1'b0, 1'b0);
            end
        end
        chk_gap = 1'b0;

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
